mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between an instruction-fetch requester and a data
// requester. At most one memory transaction is outstanding at a time. Data
// normally wins arbitration. A starvation counter forces a fetch grant after
// STARVE_MAX consecutive data grants that were made while a fetch was waiting.
//
// Handshake semantics (all on posedge clk):
//   requester side : if_req / d_req rise with the command and are held high
//                    until the matching ready pulse. Ready is a one-cycle
//                    pulse, and rdata is valid only in that cycle. rdata then
//                    holds its value until the next pulse. If the request is
//                    dropped before the response, the transaction still runs
//                    to completion, but no ready pulse is produced.
//   memory side    : mem_req is held high with a stable command until a cycle
//                    in which mem_gnt=1. The response is the first cycle with
//                    mem_rvalid=1 after that grant. This applies to reads and
//                    to writes. mem_gnt and mem_rvalid are ignored whenever
//                    they are not expected.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   if_req, if_addr               fetch request / address
//   if_ready, if_rdata            fetch completion pulse / instruction word
//   d_req, d_we, d_addr, d_wdata  data request / write enable / address / data
//   d_ready, d_rdata              data completion pulse / load data
//   mem_req, mem_we, mem_addr,
//   mem_wdata                     command to the shared memory port
//   mem_gnt                       memory accepts the command
//   mem_rvalid, mem_rdata         memory response
//   PC_Write                      low while a fetch is outstanding
//   dbg_state_o                   FSM state (0 IDLE, 1 REQ, 2 WAIT)
//   dbg_starve_o                  current starvation count
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4,   // must be >= 1
    parameter int AW         = 32,
    localparam int SW        = $clog2(STARVE_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ready,
    output logic [AW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [AW-1:0] d_wdata,
    output logic          d_ready,
    output logic [AW-1:0] d_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [AW-1:0] mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [AW-1:0] mem_rdata,
    output logic          PC_Write,
    output logic [1:0]    dbg_state_o,
    output logic [SW-1:0] dbg_starve_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic          OWN_IF     = 1'b0;
    localparam logic          OWN_D      = 1'b1;
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic [AW-1:0]   if_rdata_q, d_rdata_q;
    logic            fetch_win;

    // A fetch wins only when there is no data request, or when it has already
    // waited through STARVE_MAX data grants.
    assign fetch_win = if_req && (!d_req || (starve_q == STARVE_LIM));

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        starve_d = starve_q;
        mem_req  = 1'b0;
        if_ready = 1'b0;
        d_ready  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    state_d = ST_REQ;
                    if (fetch_win) begin
                        owner_d = OWN_IF;
                        we_d    = 1'b0;
                        addr_d  = if_addr;
                        wdata_d = '0;
                    end else begin
                        owner_d = OWN_D;
                        we_d    = d_we;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                    end
                end
            end
            ST_REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    state_d = ST_IDLE;
                    // An owner that has dropped its request gets no pulse,
                    // and the response is discarded.
                    if (owner_q == OWN_IF) begin
                        if_ready = if_req;
                    end else begin
                        d_ready = d_req;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The count only means something while a fetch is waiting.
        if (!if_req) begin
            starve_d = '0;
        end else if (state_q == ST_IDLE) begin
            if (fetch_win) begin
                starve_d = '0;
            end else if (d_req && (starve_q != STARVE_LIM)) begin
                starve_d = starve_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            starve_q   <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            starve_q <= starve_d;
            if (if_ready) begin
                if_rdata_q <= mem_rdata;
            end
            if (d_ready) begin
                d_rdata_q <= mem_rdata;
            end
        end
    end

    // rdata follows mem_rdata in the ready cycle itself, then holds.
    assign if_rdata     = if_ready ? mem_rdata : if_rdata_q;
    assign d_rdata      = d_ready ? mem_rdata : d_rdata_q;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign PC_Write     = ~(if_req & ~if_ready);
    assign dbg_state_o  = state_q;
    assign dbg_starve_o = starve_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios with literal expectations,
// followed by randomized requesters and memory. A transaction-level model
// predicts every output on every cycle.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int AW = 32;
  localparam int SW = $clog2(STARVE_MAX + 1);

  // ---------------- clock / reset / DUT ----------------
  logic clk;
  logic rst_n;
  logic if_req, d_req, d_we, mem_gnt, mem_rvalid;
  logic [AW-1:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic if_ready, d_ready, mem_req, mem_we, pc_write;
  logic [AW-1:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [1:0] dbg_state;
  logic [SW-1:0] dbg_starve;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_MAX(STARVE_MAX), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .PC_Write(pc_write), .dbg_state_o(dbg_state), .dbg_starve_o(dbg_starve)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One record describes the transaction in flight: whether it exists,
  // whether memory has accepted it, who owns it and what it carries.
  bit m_busy, m_acc, m_owner_d;
  logic m_we;
  logic [AW-1:0] m_addr, m_wdata, m_ifrd, m_drd;
  int m_starve;

  always @(negedge clk) begin
    bit e_mreq, e_resp, e_ifr, e_dr, granted, fw;
    logic [AW-1:0] e_ifrd, e_drd;
    int e_st;
    if (!rst_n) begin
      m_busy = 0; m_acc = 0; m_owner_d = 0; m_we = 0;
      m_addr = '0; m_wdata = '0; m_ifrd = '0; m_drd = '0; m_starve = 0;
    end
    e_mreq = m_busy && !m_acc;
    e_resp = m_busy && m_acc && mem_rvalid;
    e_ifr  = e_resp && !m_owner_d && if_req;
    e_dr   = e_resp && m_owner_d && d_req;
    e_ifrd = e_ifr ? mem_rdata : m_ifrd;
    e_drd  = e_dr ? mem_rdata : m_drd;
    e_st   = !m_busy ? 0 : (!m_acc ? 1 : 2);

    chk("mem_req", {31'd0, mem_req}, {31'd0, e_mreq});
    chk("mem_we", {31'd0, mem_we}, {31'd0, m_we});
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("if_ready", {31'd0, if_ready}, {31'd0, e_ifr});
    chk("d_ready", {31'd0, d_ready}, {31'd0, e_dr});
    chk("if_rdata", if_rdata, e_ifrd);
    chk("d_rdata", d_rdata, e_drd);
    chk("PC_Write", {31'd0, pc_write}, {31'd0, !(if_req && !e_ifr)});
    chk("state", {30'd0, dbg_state}, e_st);
    chk("starve", 32'(dbg_starve), m_starve);

    if (rst_n) begin
      granted = 0;
      fw = 0;
      if (!m_busy) begin
        if (if_req || d_req) begin
          granted = 1;
          fw = if_req && (!d_req || m_starve == STARVE_MAX);
          m_owner_d = !fw;
          m_we      = fw ? 1'b0 : d_we;
          m_addr    = fw ? if_addr : d_addr;
          m_wdata   = fw ? '0 : d_wdata;
          m_busy    = 1;
          m_acc     = 0;
        end
      end else if (e_mreq) begin
        if (mem_gnt) m_acc = 1;
      end else if (e_resp) begin
        m_busy = 0;
      end
      if (e_ifr) m_ifrd = mem_rdata;
      if (e_dr) m_drd = mem_rdata;
      if (!if_req) m_starve = 0;
      else if (granted && fw) m_starve = 0;
      else if (granted) m_starve = (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic quiet();
    if_req = 0; d_req = 0; d_we = 0; mem_gnt = 0; mem_rvalid = 0;
  endtask

  // ---------------- stimulus ----------------
  logic exp_order[$];
  logic got_order[$];
  int n_d;
  bit saw_if, if_seen, d_seen, if_drop, d_drop;
  logic [31:0] starve_at_if;

  initial begin
    rst_n = 0; quiet();
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;

    // reset state
    look();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
    chk("rst_d_ready", {31'd0, d_ready}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_pc_write", {31'd0, pc_write}, 32'd1);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    step(); rst_n = 1;

    // single fetch, minimum latency
    step(); if_req = 1; if_addr = 32'h100; mem_gnt = 1;
    look(); chk("f_c0_pcw", {31'd0, pc_write}, 32'd0);
            chk("f_c0_mreq", {31'd0, mem_req}, 32'd0);
    step();
    look(); chk("f_c1_mreq", {31'd0, mem_req}, 32'd1);
            chk("f_c1_addr", mem_addr, 32'h100);
            chk("f_c1_we", {31'd0, mem_we}, 32'd0);
            chk("f_c1_pcw", {31'd0, pc_write}, 32'd0);
    step(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h00500093;
    look(); chk("f_c2_ready", {31'd0, if_ready}, 32'd1);
            chk("f_c2_rdata", if_rdata, 32'h00500093);
            chk("f_c2_mreq", {31'd0, mem_req}, 32'd0);
    step(); if_req = 0; mem_rvalid = 0; mem_rdata = 32'h0;
    look(); chk("f_c3_ready", {31'd0, if_ready}, 32'd0);
            chk("f_c3_hold", if_rdata, 32'h00500093);
            chk("f_c3_pcw", {31'd0, pc_write}, 32'd1);

    // collision: data write first, then fetch
    step(); if_req = 1; if_addr = 32'h200; d_req = 1; d_we = 1;
            d_addr = 32'h40; d_wdata = 32'hDEAD; mem_gnt = 1;
    step();
    look(); chk("c_wr_we", {31'd0, mem_we}, 32'd1);
            chk("c_wr_addr", mem_addr, 32'h40);
            chk("c_wr_wdata", mem_wdata, 32'hDEAD);
    step(); mem_rvalid = 1;
    look(); chk("c_d_ready", {31'd0, d_ready}, 32'd1);
            chk("c_if_not", {31'd0, if_ready}, 32'd0);
    step(); d_req = 0; d_we = 0; mem_rvalid = 0;
    step();
    look(); chk("c_f_mreq", {31'd0, mem_req}, 32'd1);
            chk("c_f_addr", mem_addr, 32'h200);
            chk("c_f_we", {31'd0, mem_we}, 32'd0);
    step(); mem_rvalid = 1; mem_rdata = 32'h1234;
    look(); chk("c_if_ready", {31'd0, if_ready}, 32'd1);
    step(); quiet();

    // starvation: 4 data grants, 1 fetch, then data resumes
    step(); if_req = 1; if_addr = 32'h300; d_req = 1; d_we = 1; d_addr = 32'h80;
            mem_gnt = 1; mem_rvalid = 1;
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    got_order.delete(); n_d = 0; saw_if = 0; starve_at_if = 32'hFFFF_FFFF;
    for (int c = 0; c < 60 && got_order.size() < 7; c++) begin
      look();
      if (d_ready) begin got_order.push_back(1'b1); n_d++; end
      if (if_ready) begin got_order.push_back(1'b0); saw_if = 1; starve_at_if = 32'(dbg_starve); end
      step();
      if (n_d >= 6) d_req = 0;
      if (saw_if) if_req = 0;
    end
    chk("sv_pulses", got_order.size(), 7);
    for (int i = 0; i < got_order.size() && i < 7; i++)
      chk($sformatf("sv_order%0d", i), {31'd0, got_order[i]}, {31'd0, exp_order[i]});
    chk("sv_starve_clr", starve_at_if, 32'd0);
    quiet();

    // backpressure: command stable, early rvalid ignored
    step(); d_req = 1; d_addr = 32'h55; mem_rvalid = 1;
    look(); chk("bp_c0_ready", {31'd0, d_ready}, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      step(); if (k == 2) d_addr = 32'h99;
      look(); chk("bp_mreq", {31'd0, mem_req}, 32'd1);
              chk("bp_addr", mem_addr, 32'h55);
              chk("bp_state", {30'd0, dbg_state}, 32'd1);
              chk("bp_ready", {31'd0, d_ready}, 32'd0);
    end
    step(); mem_gnt = 1; mem_rvalid = 0;
    look(); chk("bp_gnt_mreq", {31'd0, mem_req}, 32'd1);
    step(); mem_gnt = 0;
    look(); chk("bp_wait", {30'd0, dbg_state}, 32'd2);
            chk("bp_wait_mreq", {31'd0, mem_req}, 32'd0);
    step(); mem_rvalid = 1; mem_rdata = 32'hAB;
    look(); chk("bp_ready1", {31'd0, d_ready}, 32'd1);
            chk("bp_rdata", d_rdata, 32'hAB);
    step(); quiet();
    look(); chk("bp_hold", d_rdata, 32'hAB);

    // reset while waiting, late rvalid afterwards
    step(); d_req = 1; d_addr = 32'h10; mem_gnt = 1;
    step();
    step(); mem_gnt = 0;
    look(); chk("rw_wait", {30'd0, dbg_state}, 32'd2);
    step(); rst_n = 0;
    look(); chk("rw_state", {30'd0, dbg_state}, 32'd0);
            chk("rw_mreq", {31'd0, mem_req}, 32'd0);
            chk("rw_addr", mem_addr, 32'd0);
            chk("rw_rdata", d_rdata, 32'd0);
    step(); rst_n = 1; d_req = 0; mem_rvalid = 1;
    look(); chk("rw_late_ready", {31'd0, d_ready}, 32'd0);
            chk("rw_late_state", {30'd0, dbg_state}, 32'd0);
    step(); quiet();

    // dropped data request, pending fetch served next
    step(); d_req = 1; d_addr = 32'h20; if_req = 1; if_addr = 32'h400; mem_gnt = 1;
    step();
    step(); d_req = 0;
    look(); chk("dr_wait", {30'd0, dbg_state}, 32'd2);
    step(); mem_rvalid = 1; mem_rdata = 32'hBAD;
    look(); chk("dr_no_ready", {31'd0, d_ready}, 32'd0);
            chk("dr_rdata", d_rdata, 32'd0);
    step(); mem_rvalid = 0;
    step();
    look(); chk("dr_f_addr", mem_addr, 32'h400);
            chk("dr_f_mreq", {31'd0, mem_req}, 32'd1);
    step(); mem_rvalid = 1; mem_rdata = 32'h77;
    look(); chk("dr_if_ready", {31'd0, if_ready}, 32'd1);
    step(); quiet();

    // randomized traffic
    if_seen = 0; d_seen = 0; if_drop = 0; d_drop = 0;
    for (int n = 0; n < 4000; n++) begin
      step();
      rst_n = ($urandom_range(0, 299) != 0);
      if (if_req) begin
        if (if_seen) begin if_req = ($urandom_range(0, 1) == 1); if_addr = $urandom; end
        else if ($urandom_range(0, 40) == 0) begin if_req = 0; if_drop = 1; end
      end else if (!if_drop && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = $urandom;
      end
      if (d_req) begin
        if (d_seen) begin
          d_req = ($urandom_range(0, 1) == 1);
          d_we = $urandom_range(0, 1); d_addr = $urandom; d_wdata = $urandom;
        end else if ($urandom_range(0, 40) == 0) begin d_req = 0; d_drop = 1; end
      end else if (!d_drop && $urandom_range(0, 1) == 0) begin
        d_req = 1; d_we = $urandom_range(0, 1); d_addr = $urandom; d_wdata = $urandom;
      end
      mem_gnt = $urandom_range(0, 1);
      mem_rvalid = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      look();
      if_seen = if_ready;
      d_seen = d_ready;
      // after abandoning a request, wait for the port to go idle before asking again
      if (dbg_state == 2'd0) begin if_drop = 0; d_drop = 0; end
    end

    step(); quiet();
    look();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
